// File: rtl/booth_pp_reduction_pipe.sv
// booth_pp_reduction_pipe
//
// Reduces the six aligned radix-8 Booth partial products of a 16x16 signed
// multiply to the 32-bit product. There are three register stages:
//   S1: two 3:2 carry-save adders, one on {pp0,pp1,pp2} and one on {pp3,pp4,pp5}
//   S2: a 4:2 reduction built from two 3:2 CSAs
//   S3: a carry-propagate add, keeping the low P_W bits
// Each stage is gated by valid/ready. Empty stages let data advance even when
// the output is stalled.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (clears valid bits and product)
//   pp0..pp5   PP_W-bit partial products, pp_k already weighted by 2^(3k)
//   in_valid   partial products valid
//   in_ready   pipeline can accept this cycle (independent of in_valid)
//   product    P_W-bit signed product
//   out_valid  product valid (registered, independent of out_ready)
//   out_ready  downstream accepts product

`timescale 1ns/1ps

module booth_pp_reduction_pipe #(
    parameter int unsigned PP_W = 34,
    parameter int unsigned P_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PP_W-1:0] pp0,
    input  logic [PP_W-1:0] pp1,
    input  logic [PP_W-1:0] pp2,
    input  logic [PP_W-1:0] pp3,
    input  logic [PP_W-1:0] pp4,
    input  logic [PP_W-1:0] pp5,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [P_W-1:0]  product,
    output logic            out_valid,
    input  logic            out_ready
);

    // 3:2 compressor, modulo 2^PP_W: the carry shift drops the old MSB.
    function automatic logic [PP_W-1:0] csa_sum(input logic [PP_W-1:0] x,
                                                 input logic [PP_W-1:0] y,
                                                 input logic [PP_W-1:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [PP_W-1:0] csa_carry(input logic [PP_W-1:0] x,
                                                   input logic [PP_W-1:0] y,
                                                   input logic [PP_W-1:0] z);
        logic [PP_W-1:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        return {maj[PP_W-2:0], 1'b0};
    endfunction

    // Stage state
    logic            v1_q, v2_q, v3_q;
    logic [PP_W-1:0] sa_q, ca_q, sb_q, cb_q;
    logic [PP_W-1:0] s2_q, c2_q;
    logic [P_W-1:0]  product_q;

    // Bubble-collapsing ready chain: a stage may load if it is empty or if
    // the stage below is moving.
    logic adv1, adv2, adv3;

    always_comb begin
        adv3 = ~v3_q | out_ready;
        adv2 = ~v2_q | adv3;
        adv1 = ~v1_q | adv2;
    end

    assign in_ready  = adv1;
    assign out_valid = v3_q;
    assign product   = product_q;

    // S1 next-state
    logic [PP_W-1:0] sa_d, ca_d, sb_d, cb_d;

    always_comb begin
        sa_d = csa_sum(pp0, pp1, pp2);
        ca_d = csa_carry(pp0, pp1, pp2);
        sb_d = csa_sum(pp3, pp4, pp5);
        cb_d = csa_carry(pp3, pp4, pp5);
    end

    // S2 next-state: (sA, cA, sB) -> (s', c'), then (s', c', cB) -> (s2, c2)
    logic [PP_W-1:0] sp, cp, s2_d, c2_d;

    always_comb begin
        sp   = csa_sum(sa_q, ca_q, sb_q);
        cp   = csa_carry(sa_q, ca_q, sb_q);
        s2_d = csa_sum(sp, cp, cb_q);
        c2_d = csa_carry(sp, cp, cb_q);
    end

    // S3 next-state: full-width add, upper bits are discarded by truncation
    logic [PP_W-1:0] sum3;
    logic [P_W-1:0]  product_d;
    logic            unused_sum_hi;

    always_comb begin
        sum3      = s2_q + c2_q;
        product_d = sum3[P_W-1:0];
    end

    assign unused_sum_hi = ^sum3[PP_W-1:P_W];

    // Control state and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            product_q <= '0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) begin
                v3_q <= v2_q;
                // Bubbles leave the last valid product visible on the port.
                if (v2_q) product_q <= product_d;
            end
        end
    end

    // Carry-save datapath: contents are meaningless while the stage is empty,
    // so these registers need no reset.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            sa_q <= sa_d;
            ca_q <= ca_d;
            sb_q <= sb_d;
            cb_q <= cb_d;
        end
        if (adv2 && v1_q) begin
            s2_q <= s2_d;
            c2_q <= c2_d;
        end
    end

endmodule

// File: tb/tb_booth_pp_reduction_pipe.sv
`timescale 1ns/1ps

module tb_booth_pp_reduction_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] pp [6];
    logic        in_valid;
    logic        in_ready;
    logic [31:0] product;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    // Model: expected product of the vector currently driven, and an
    // in-order queue of expectations for accepted inputs.
    logic [31:0] exp_cur;
    logic [31:0] exp_q [$];
    logic        hold_prev = 1'b0;
    logic [31:0] hold_val  = '0;

    always #5 clk = ~clk;

    booth_pp_reduction_pipe #(
        .PP_W (34),
        .P_W  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pp0       (pp[0]),
        .pp1       (pp[1]),
        .pp2       (pp[2]),
        .pp3       (pp[3]),
        .pp4       (pp[4]),
        .pp5       (pp[5]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Radix-8 Booth encoding of b, each digit times a, aligned to 2^(3k).
    // Expected value is the plain integer product.
    task automatic set_ab(input logic signed [15:0] a, input logic signed [15:0] b);
        logic [18:0] bz;
        int          d;
        longint      p;
        longint      prod;
        bz = {{2{b[15]}}, b, 1'b0};
        for (int k = 0; k < 6; k++) begin
            d = -4 * int'(bz[3*k+3]) + 2 * int'(bz[3*k+2]) + int'(bz[3*k+1]) + int'(bz[3*k]);
            p = longint'(d) * longint'(a);
            p = p <<< (3 * k);
            pp[k] = p[33:0];
        end
        prod    = longint'(a) * longint'(b);
        exp_cur = prod[31:0];
    endtask

    task automatic set_raw(input logic [33:0] p0, input logic [33:0] p1, input logic [33:0] p2,
                           input logic [33:0] p3, input logic [33:0] p4, input logic [33:0] p5);
        logic [33:0] s;
        pp[0] = p0; pp[1] = p1; pp[2] = p2; pp[3] = p3; pp[4] = p4; pp[5] = p5;
        s       = p0 + p1 + p2 + p3 + p4 + p5;
        exp_cur = s[31:0];
    endtask

    // Called at posedge+1; holds in_valid until accepted (bounded).
    task automatic push_one();
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 50 cycles");
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'h0000;
            3:       return 16'hffff;
            default: return 16'($urandom);
        endcase
    endfunction

    // Compare process: runs every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'(1'b1));
                chk("hold_product", 64'(product), 64'(hold_val));
            end
            if (!out_valid || out_ready) chk("in_ready_chain", 64'(in_ready), 64'(1'b1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got %0h expected no output", product);
                end else begin
                    chk("product", 64'(product), 64'(exp_q.pop_front()));
                    pops++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(exp_cur);
            hold_prev = out_valid && !out_ready;
            hold_val  = product;
        end
    end

    initial begin
        int n_acc;
        int cnt;
        int sent;
        int cyc;
        bit acc_now;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_raw('0, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
        chk("reset_product", 64'(product), 64'(32'h0));
        chk("reset_in_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;

        // Single input, exact 3-cycle latency, one-cycle output pulse
        set_raw(34'd5, '0, '0, '0, '0, '0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid_c1", 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        chk("t1_valid_c2", 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        chk("t1_valid_c3", 64'(out_valid), 64'(1'b1));
        chk("t1_product", 64'(product), 64'(32'h00000005));
        @(negedge clk);
        chk("t1_valid_c4", 64'(out_valid), 64'(1'b0));
        drain();

        // Back-to-back encoder vectors, consecutive results
        set_ab(-16'sd32768, -16'sd32768);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        set_ab(16'sd32767, -16'sd32768);
        @(posedge clk);
        #1;
        set_ab(-16'sd1, 16'sd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid_a", 64'(out_valid), 64'(1'b1));
        chk("t2_prod_a", 64'(product), 64'(32'h40000000));
        @(negedge clk);
        chk("t2_valid_b", 64'(out_valid), 64'(1'b1));
        chk("t2_prod_b", 64'(product), 64'(32'hC0008000));
        @(negedge clk);
        chk("t2_valid_c", 64'(out_valid), 64'(1'b1));
        chk("t2_prod_c", 64'(product), 64'(32'hFFFFFFFF));
        @(posedge clk);
        #1;
        drain();

        // Truncation of bits above P_W
        set_raw(34'h3_0000_0001, '0, '0, '0, '0, '0);
        push_one();
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("t3_product", 64'(product), 64'(32'h00000001));
        drain();

        // Backpressure: only three fit while out_ready is low
        out_ready = 1'b0;
        n_acc     = 0;
        for (int c = 0; c < 8; c++) begin
            set_ab(16'(n_acc * 1234 + 7), 16'(-(n_acc * 321) - 5));
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        chk("t4_accepts_stalled", 64'(n_acc), 64'(3));
        @(negedge clk);
        chk("t4_in_ready_full", 64'(in_ready), 64'(1'b0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_ab(16'(3 * 1234 + 7), 16'(-(3 * 321) - 5));
        push_one();
        set_ab(16'(4 * 1234 + 7), 16'(-(4 * 321) - 5));
        push_one();
        drain();
        chk("t4_pops", 64'(pops), 64'(10));

        // Bubble collapse: second input still accepted while output stalled
        out_ready = 1'b0;
        set_ab(16'sd1000, -16'sd999);
        push_one();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        set_ab(-16'sd12345, 16'sd321);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        drain();
        chk("t5_pops", 64'(pops), 64'(12));

        // Reset with every stage full discards everything
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ab(16'(i + 77), 16'(i * 1000 + 3));
            push_one();
        end
        @(negedge clk);
        chk("t6_full", 64'(in_ready), 64'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 64'(out_valid), 64'(1'b0));
        chk("t6_product", 64'(product), 64'(32'h0));
        chk("t6_in_ready", 64'(in_ready), 64'(1'b1));
        out_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("t6_no_stale", 64'(cnt), 64'(0));
        @(posedge clk);
        #1;

        // Random encoder-driven traffic with random handshakes
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                set_ab(rnd16(), rnd16());
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc_now = in_valid && in_ready;
            if (acc_now) sent++;
            @(posedge clk);
            #1;
            if (acc_now) in_valid = 1'b0;
            cyc++;
        end
        chk("rand_sent", 64'(sent), 64'(10000));
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        chk("total_pops", 64'(pops), 64'(10012));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
